// File: rtl/scr1_pipe_wb_pkg.sv
// Writeback stage shared types and constants.
// Entry layout for buffered load results and scoreboard helpers.
package scr1_pipe_wb_pkg;

  localparam int SCR1_WB_LD_MAX     = 2;
  localparam int SCR1_WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } type_scr1_wb_entry_s;

  // One-hot over x1..x31; x0 maps to an empty mask.
  function automatic logic [31:1] wb_addr_mask(
    input logic [4:0] a
  );
    logic [31:0] m;
    m = 32'd1 << a;
    return m[31:1];
  endfunction

endpackage

// File: rtl/scr1_pipe_wb_fifo.sv
// Two-entry registered FIFO holding LSU results for writeback.
// Pointers and count reset; data storage does not.
module scr1_pipe_wb_fifo
  import scr1_pipe_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  type_scr1_wb_entry_s wdata,
  output type_scr1_wb_entry_s rdata,
  output logic                full,
  output logic                empty
);

  type_scr1_wb_entry_s mem [SCR1_WB_FIFO_DEPTH];

  logic       wptr;
  logic       rptr;
  logic [1:0] cnt;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO may take a push when the head leaves at the same edge.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push_ok) wptr <= ~wptr;
      if (pop_ok)  rptr <= ~rptr;
      if (push_ok && !pop_ok)
        cnt <= cnt + 2'd1;
      else if (!push_ok && pop_ok)
        cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/scr1_pipe_mprf_wb.sv
// Writeback stage: merges ALU and LSU results onto the MPRF write port
// and tracks registers with outstanding loads.
module scr1_pipe_mprf_wb #(
  parameter int SCR1_WB_LD_MAX =
    scr1_pipe_wb_pkg::SCR1_WB_LD_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu2wb_vd_i,
  input  logic [4:0]  alu2wb_rd_addr_i,
  input  logic [31:0] alu2wb_rd_data_i,
  input  logic        lsu2wb_vd_i,
  input  logic [4:0]  lsu2wb_rd_addr_i,
  input  logic [31:0] lsu2wb_rd_data_i,
  output logic        wb2lsu_rdy_o,
  input  logic        exu2wb_ld_issue_i,
  input  logic [4:0]  exu2wb_ld_rd_addr_i,
  output logic        wb2exu_ld_rdy_o,
  input  logic [4:0]  exu2wb_rs1_addr_i,
  input  logic [4:0]  exu2wb_rs2_addr_i,
  input  logic [4:0]  exu2wb_rd_addr_i,
  output logic        wb2exu_hazard_o,
  output logic        exu2mprf_w_req_o,
  output logic [4:0]  exu2mprf_rd_addr_o,
  output logic [31:0] exu2mprf_rd_data_o
);

  import scr1_pipe_wb_pkg::*;

  localparam int CW = $clog2(SCR1_WB_LD_MAX + 1);

  type_scr1_wb_entry_s lsu_ent;
  type_scr1_wb_entry_s head;

  logic          fifo_full;
  logic          fifo_empty;
  logic          lsu_push;
  logic          fifo_pop;
  logic          wb_lsu;
  logic          ld_acc;
  logic [31:1]   busy;
  logic [31:1]   set_mask;
  logic [31:1]   clr_mask;
  logic [31:1]   qry_mask;
  logic [CW-1:0] ld_cnt;

  assign lsu_ent  = '{addr: lsu2wb_rd_addr_i,
                      data: lsu2wb_rd_data_i};
  assign wb2lsu_rdy_o = ~fifo_full;
  assign lsu_push = lsu2wb_vd_i & wb2lsu_rdy_o;
  assign fifo_pop = ~alu2wb_vd_i & ~fifo_empty;

  scr1_pipe_wb_fifo i_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lsu_push),
    .pop   (fifo_pop),
    .wdata (lsu_ent),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exu2mprf_w_req_o   <= 1'b0;
      exu2mprf_rd_addr_o <= '0;
      exu2mprf_rd_data_o <= '0;
      wb_lsu             <= 1'b0;
    end else begin
      unique case (1'b1)
        alu2wb_vd_i: begin
          exu2mprf_w_req_o   <= |alu2wb_rd_addr_i;
          exu2mprf_rd_addr_o <= alu2wb_rd_addr_i;
          exu2mprf_rd_data_o <= alu2wb_rd_data_i;
          wb_lsu             <= 1'b0;
        end
        fifo_pop: begin
          exu2mprf_w_req_o   <= |head.addr;
          exu2mprf_rd_addr_o <= head.addr;
          exu2mprf_rd_data_o <= head.data;
          wb_lsu             <= 1'b1;
        end
        default: begin
          exu2mprf_w_req_o   <= 1'b0;
          wb_lsu             <= 1'b0;
        end
      endcase
    end
  end

  assign wb2exu_ld_rdy_o = ld_cnt < CW'(SCR1_WB_LD_MAX);
  assign ld_acc   = exu2wb_ld_issue_i & wb2exu_ld_rdy_o;
  assign set_mask = ld_acc
                  ? wb_addr_mask(exu2wb_ld_rd_addr_i) : '0;
  assign clr_mask = wb_lsu
                  ? wb_addr_mask(exu2mprf_rd_addr_o) : '0;

  // Clear is applied first so a same-edge set survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= '0;
      ld_cnt <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (ld_acc && !wb_lsu)
        ld_cnt <= ld_cnt + CW'(1);
      else if (!ld_acc && wb_lsu)
        ld_cnt <= ld_cnt - CW'(1);
    end
  end

  assign qry_mask = wb_addr_mask(exu2wb_rs1_addr_i)
                  | wb_addr_mask(exu2wb_rs2_addr_i)
                  | wb_addr_mask(exu2wb_rd_addr_i);
  assign wb2exu_hazard_o = |(busy & qry_mask);

  a_ld_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    ld_acc |-> ~|(busy & wb_addr_mask(exu2wb_ld_rd_addr_i)));

  a_alu_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    alu2wb_vd_i |-> ~|(busy & wb_addr_mask(alu2wb_rd_addr_i)));

  a_lsu_cnt: assert property (
    @(posedge clk) disable iff (!rst_n)
    lsu2wb_vd_i |-> (ld_cnt != '0));

endmodule

// File: tb/tb_scr1_pipe_mprf_wb.sv
// Scoreboard bench for the writeback stage.
// Directed scenarios followed by constrained-random traffic.
module tb_scr1_pipe_mprf_wb;

  localparam int MAX = 2;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu2wb_vd_i;
  logic [4:0]  alu2wb_rd_addr_i;
  logic [31:0] alu2wb_rd_data_i;
  logic        lsu2wb_vd_i;
  logic [4:0]  lsu2wb_rd_addr_i;
  logic [31:0] lsu2wb_rd_data_i;
  logic        wb2lsu_rdy_o;
  logic        exu2wb_ld_issue_i;
  logic [4:0]  exu2wb_ld_rd_addr_i;
  logic        wb2exu_ld_rdy_o;
  logic [4:0]  exu2wb_rs1_addr_i;
  logic [4:0]  exu2wb_rs2_addr_i;
  logic [4:0]  exu2wb_rd_addr_i;
  logic        wb2exu_hazard_o;
  logic        exu2mprf_w_req_o;
  logic [4:0]  exu2mprf_rd_addr_o;
  logic [31:0] exu2mprf_rd_data_o;

  exp_t       exp_q[$];
  ent_t       fifo_q[$];
  logic [4:0] pend_q[$];
  bit         busy[32];
  int         outst;
  bit         pres_lsu;
  logic [4:0] pres_addr;
  int         cyc;
  int         n_chk;
  int         n_fail;
  logic [4:0] last_ld;

  always #5 clk = ~clk;

  scr1_pipe_mprf_wb #(.SCR1_WB_LD_MAX(MAX)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alu2wb_vd_i         (alu2wb_vd_i),
    .alu2wb_rd_addr_i    (alu2wb_rd_addr_i),
    .alu2wb_rd_data_i    (alu2wb_rd_data_i),
    .lsu2wb_vd_i         (lsu2wb_vd_i),
    .lsu2wb_rd_addr_i    (lsu2wb_rd_addr_i),
    .lsu2wb_rd_data_i    (lsu2wb_rd_data_i),
    .wb2lsu_rdy_o        (wb2lsu_rdy_o),
    .exu2wb_ld_issue_i   (exu2wb_ld_issue_i),
    .exu2wb_ld_rd_addr_i (exu2wb_ld_rd_addr_i),
    .wb2exu_ld_rdy_o     (wb2exu_ld_rdy_o),
    .exu2wb_rs1_addr_i   (exu2wb_rs1_addr_i),
    .exu2wb_rs2_addr_i   (exu2wb_rs2_addr_i),
    .exu2wb_rd_addr_i    (exu2wb_rd_addr_i),
    .wb2exu_hazard_o     (wb2exu_hazard_o),
    .exu2mprf_w_req_o    (exu2mprf_w_req_o),
    .exu2mprf_rd_addr_o  (exu2mprf_rd_addr_o),
    .exu2mprf_rd_data_o  (exu2mprf_rd_data_o)
  );

  task automatic chk(input string nm,
                     input logic act,
                     input logic want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b cyc %0d",
               nm, act, want, cyc);
    end
  endtask

  task automatic idle();
    alu2wb_vd_i         = 1'b0;
    alu2wb_rd_addr_i    = '0;
    alu2wb_rd_data_i    = '0;
    lsu2wb_vd_i         = 1'b0;
    lsu2wb_rd_addr_i    = '0;
    lsu2wb_rd_data_i    = '0;
    exu2wb_ld_issue_i   = 1'b0;
    exu2wb_ld_rd_addr_i = '0;
    exu2wb_rs1_addr_i   = '0;
    exu2wb_rs2_addr_i   = '0;
    exu2wb_rd_addr_i    = '0;
  endtask

  task automatic model_reset();
    fifo_q.delete();
    pend_q.delete();
    foreach (busy[i]) busy[i] = 1'b0;
    outst    = 0;
    pres_lsu = 1'b0;
  endtask

  // Reference: ALU wins the port, otherwise the oldest buffered load
  // result; a load result is retired one edge after it is presented.
  task automatic model_edge();
    int   sz;
    int   ob;
    ent_t e;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sz = fifo_q.size();
    ob = outst;
    if (pres_lsu) begin
      outst--;
      busy[pres_addr] = 1'b0;
    end
    if (exu2wb_ld_issue_i && ob < MAX) begin
      outst++;
      if (exu2wb_ld_rd_addr_i != 0)
        busy[exu2wb_ld_rd_addr_i] = 1'b1;
      pend_q.push_back(exu2wb_ld_rd_addr_i);
    end
    pres_lsu = 1'b0;
    if (alu2wb_vd_i) begin
      if (alu2wb_rd_addr_i != 0)
        exp_q.push_back('{alu2wb_rd_addr_i,
                          alu2wb_rd_data_i, cyc});
    end else if (sz > 0) begin
      e = fifo_q.pop_front();
      pres_lsu  = 1'b1;
      pres_addr = e.addr;
      if (e.addr != 0)
        exp_q.push_back('{e.addr, e.data, cyc});
    end
    if (lsu2wb_vd_i && sz < 2) begin
      fifo_q.push_back('{lsu2wb_rd_addr_i,
                         lsu2wb_rd_data_i});
      void'(pend_q.pop_front());
    end
  endtask

  task automatic tick();
    if (lsu2wb_vd_i) begin
      if (pend_q.size() == 0) lsu2wb_vd_i = 1'b0;
      else lsu2wb_rd_addr_i = pend_q[0];
    end
    #1;
    chk("lsu_rdy", wb2lsu_rdy_o, fifo_q.size() < 2);
    chk("ld_rdy", wb2exu_ld_rdy_o, outst < MAX);
    chk("hazard", wb2exu_hazard_o,
        busy[exu2wb_rs1_addr_i] |
        busy[exu2wb_rs2_addr_i] |
        busy[exu2wb_rd_addr_i]);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
  endtask

  task automatic alu(input logic [4:0] a,
                     input logic [31:0] d);
    alu2wb_vd_i      = 1'b1;
    alu2wb_rd_addr_i = a;
    alu2wb_rd_data_i = d;
  endtask

  task automatic issue(input logic [4:0] a);
    exu2wb_ld_issue_i   = 1'b1;
    exu2wb_ld_rd_addr_i = a;
    last_ld             = a;
  endtask

  task automatic lsu(input logic [31:0] d);
    lsu2wb_vd_i      = 1'b1;
    lsu2wb_rd_data_i = d;
  endtask

  task automatic qry(input logic [4:0] a,
                     input logic [4:0] b);
    exu2wb_rs1_addr_i = a;
    exu2wb_rs2_addr_i = b;
    exu2wb_rd_addr_i  = a;
  endtask

  function automatic logic [4:0] pick_free();
    logic [4:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 5'($urandom_range(0, 31));
      if (!busy[a]) return a;
    end
    return 5'd0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exu2mprf_w_req_o === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexp: got a=%0d d=%h want none cyc %0d",
                 exu2mprf_rd_addr_o, exu2mprf_rd_data_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== exu2mprf_rd_addr_o ||
            e.data !== exu2mprf_rd_data_o ||
            e.cyc != cyc) begin
          n_fail++;
          $display("FAIL wr: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                   exu2mprf_rd_addr_o, exu2mprf_rd_data_o, cyc,
                   e.addr, e.data, e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      n_chk++;
      n_fail++;
      e = exp_q.pop_front();
      $display("FAIL wr_missing: got w_req=%b want a=%0d d=%h c=%0d",
               exu2mprf_w_req_o, e.addr, e.data, e.cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    last_ld = '0;
    model_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    alu(5'd5, 32'hA5A5_0001); tick();
    tick(); tick();

    issue(5'd7); tick();
    lsu(32'h0000_1234); qry(5'd7, 5'd0); tick();
    repeat (4) begin qry(5'd7, 5'd0); tick(); end

    issue(5'd3); tick();
    issue(5'd4); tick();
    issue(5'd9); qry(5'd9, 5'd3); tick();
    lsu(32'hCAFE_0003); qry(5'd3, 5'd4); tick();
    lsu(32'hCAFE_0004); qry(5'd3, 5'd4); tick();
    repeat (4) begin qry(5'd3, 5'd4); tick(); end

    issue(5'd0); tick();
    lsu(32'hFFFF_FFFF); qry(5'd0, 5'd0); tick();
    repeat (3) begin qry(5'd0, 5'd0); tick(); end

    issue(5'd10); tick();
    issue(5'd11); tick();
    for (int i = 0; i < 4; i++) begin
      alu(5'(20 + i), $urandom);
      if (i < 2) lsu($urandom);
      qry(5'd10, 5'd11);
      tick();
    end
    repeat (3) begin qry(5'd10, 5'd11); tick(); end

    issue(5'd12); tick();
    issue(5'd13); tick();
    for (int i = 0; i < 3; i++) begin
      alu(5'd25, $urandom);
      if (i < 2) lsu($urandom);
      tick();
    end
    rst_n = 1'b0; tick();
    rst_n = 1'b1; qry(5'd12, 5'd13);
    chk("wreq_after_rst", exu2mprf_w_req_o, 1'b0);
    tick();
    tick();

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 4) < 3)
        alu(pick_free(), $urandom);
      if ($urandom_range(0, 2) == 0)
        issue(pick_free());
      if (pend_q.size() > 0 && $urandom_range(0, 1) == 0)
        lsu($urandom);
      if ($urandom_range(0, 1) == 0)
        qry(last_ld, 5'($urandom_range(0, 31)));
      else
        qry(5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      tick();
    end
    rst_n = 1'b1;
    while (pend_q.size() > 0) begin
      lsu($urandom); tick();
    end
    repeat (6) tick();

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending writes want 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
